// File: rtl/mem_stage_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_stage_param: store-source mux, synchronous data RAM with registered   |
// | reads, pipelined ALU result and a post-reset clear sweep.  Rev 1.0        |
// +--------------------------------------------------------------------------+
module mem_stage_param #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 4,
  parameter int WRITE_FIRST    = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              writeMem,
  input  logic              readMem,
  input  logic              WEaluOut,
  input  logic [1:0]        memWriteData,
  input  logic [DATA_W-1:0] ALUoutput,
  input  logic [DATA_W-1:0] MWD0,
  input  logic [DATA_W-1:0] MWD2,
  input  logic [DATA_W-1:0] MWD3,
  input  logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memOut,
  output logic              memValid,
  output logic [DATA_W-1:0] aluOut,
  output logic              stall
);

  localparam int                DEPTH  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_mem_out;
  logic              r_mem_valid;
  logic [DATA_W-1:0] r_alu_out;
  logic [DATA_W-1:0] w_wdata;
  logic              w_run;

  assign w_run = (r_state == S_RUN);

  always_comb begin
    w_wdata = MWD0;
    case (memWriteData)
      2'd0:    w_wdata = MWD0;
      2'd1:    w_wdata = ALUoutput;
      2'd2:    w_wdata = MWD2;
      default: w_wdata = MWD3;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state     <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
      r_clr_ptr   <= '0;
      r_mem_out   <= '0;
      r_mem_valid <= 1'b0;
      r_alu_out   <= '0;
    end else begin
      if (WEaluOut) begin
        r_alu_out <= ALUoutput;
      end
      case (r_state)
        S_CLEAR: begin
          r_mem_valid <= 1'b0;
          r_clr_ptr   <= r_clr_ptr + ADDR_W'(1);
          if (r_clr_ptr == c_LAST) begin
            r_state <= S_RUN;
          end
        end
        default: begin
          if (readMem) begin
            r_mem_valid <= 1'b1;
            // Write-first forwards the store data around the RAM read port.
            r_mem_out   <= ((WRITE_FIRST != 0) && writeMem) ? w_wdata : r_mem[memAddr];
          end else begin
            r_mem_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  // RAM array is never reset; only the sweep zeroes it.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      if (!w_run) begin
        r_mem[r_clr_ptr] <= '0;
      end else if (writeMem) begin
        r_mem[memAddr] <= w_wdata;
      end
    end
  end

  assign memOut   = r_mem_out;
  assign memValid = r_mem_valid;
  assign aluOut   = r_alu_out;
  assign stall    = (r_state == S_CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_param.sv
`default_nettype none
// Directed bench: write-first, read-first and no-clear instances share one stimulus set.
module tb_mem_stage_param;

  logic        CLK;
  logic        reset;
  logic        writeMem;
  logic        readMem;
  logic        WEaluOut;
  logic [1:0]  memWriteData;
  logic [15:0] ALUoutput;
  logic [15:0] MWD0;
  logic [15:0] MWD2;
  logic [15:0] MWD3;
  logic [3:0]  memAddr;

  logic [15:0] memOut1, memOut0, memOutN;
  logic        memValid1, memValid0, memValidN;
  logic [15:0] aluOut1, aluOut0, aluOutN;
  logic        stall1, stall0, stallN;

  int total = 0;
  int bad   = 0;

  mem_stage_param #(.DATA_W(16), .ADDR_W(4), .WRITE_FIRST(1), .CLEAR_ON_RESET(1)) dut_wf (
    .CLK(CLK), .reset(reset), .writeMem(writeMem), .readMem(readMem), .WEaluOut(WEaluOut),
    .memWriteData(memWriteData), .ALUoutput(ALUoutput), .MWD0(MWD0), .MWD2(MWD2), .MWD3(MWD3),
    .memAddr(memAddr), .memOut(memOut1), .memValid(memValid1), .aluOut(aluOut1), .stall(stall1)
  );

  mem_stage_param #(.DATA_W(16), .ADDR_W(4), .WRITE_FIRST(0), .CLEAR_ON_RESET(1)) dut_rf (
    .CLK(CLK), .reset(reset), .writeMem(writeMem), .readMem(readMem), .WEaluOut(WEaluOut),
    .memWriteData(memWriteData), .ALUoutput(ALUoutput), .MWD0(MWD0), .MWD2(MWD2), .MWD3(MWD3),
    .memAddr(memAddr), .memOut(memOut0), .memValid(memValid0), .aluOut(aluOut0), .stall(stall0)
  );

  mem_stage_param #(.DATA_W(16), .ADDR_W(4), .WRITE_FIRST(1), .CLEAR_ON_RESET(0)) dut_nc (
    .CLK(CLK), .reset(reset), .writeMem(writeMem), .readMem(readMem), .WEaluOut(WEaluOut),
    .memWriteData(memWriteData), .ALUoutput(ALUoutput), .MWD0(MWD0), .MWD2(MWD2), .MWD3(MWD3),
    .memAddr(memAddr), .memOut(memOutN), .memValid(memValidN), .aluOut(aluOutN), .stall(stallN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    int cnt;
    reset = 1'b1;
    step();
    step();
    total++; if (memOut1 !== 16'h0) begin bad++; $display("FAIL rst_memOut got=%h exp=0000", memOut1); end
    total++; if (memValid1 !== 1'b0) begin bad++; $display("FAIL rst_memValid got=%b exp=0", memValid1); end
    total++; if (aluOut1 !== 16'h0) begin bad++; $display("FAIL rst_aluOut got=%h exp=0000", aluOut1); end
    total++; if (stall1 !== 1'b1) begin bad++; $display("FAIL rst_stall got=%b exp=1", stall1); end
    total++; if (stallN !== 1'b0) begin bad++; $display("FAIL rst_stall_noclr got=%b exp=0", stallN); end
    reset = 1'b0;
    cnt = 0;
    while (stall1 === 1'b1 && cnt < 40) begin
      step();
      cnt++;
    end
    total++; if (cnt !== 16) begin bad++; $display("FAIL sweep_len got=%0d exp=16", cnt); end
    readMem = 1'b1;
    memAddr = 4'd5;
    step();
    total++; if (memOut1 !== 16'h0) begin bad++; $display("FAIL clr_read got=%h exp=0000", memOut1); end
    total++; if (memValid1 !== 1'b1) begin bad++; $display("FAIL clr_read_valid got=%b exp=1", memValid1); end
    readMem = 1'b0;
    step();
    total++; if (memValid1 !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b exp=0", memValid1); end
  endtask

  task automatic test_write_first();
    WEaluOut     = 1'b1;
    writeMem     = 1'b1;
    readMem      = 1'b1;
    memWriteData = 2'd1;
    ALUoutput    = 16'd17;
    memAddr      = 4'd0;
    step();
    total++; if (memOut1 !== 16'd17) begin bad++; $display("FAIL wf_fwd got=%0d exp=17", memOut1); end
    total++; if (memOut0 !== 16'd0) begin bad++; $display("FAIL rf_old got=%0d exp=0", memOut0); end
    total++; if (aluOut1 !== 16'd17) begin bad++; $display("FAIL alu_pipe got=%0d exp=17", aluOut1); end
    writeMem  = 1'b0;
    ALUoutput = 16'd1;
    step();
    total++; if (memOut1 !== 16'd17) begin bad++; $display("FAIL wf_hold got=%0d exp=17", memOut1); end
    total++; if (memOut0 !== 16'd17) begin bad++; $display("FAIL rf_next got=%0d exp=17", memOut0); end
    total++; if (aluOut1 !== 16'd1) begin bad++; $display("FAIL alu_pipe2 got=%0d exp=1", aluOut1); end
  endtask

  task automatic test_isolation();
    writeMem     = 1'b1;
    readMem      = 1'b0;
    memWriteData = 2'd1;
    ALUoutput    = 16'd1;
    memAddr      = 4'd0;
    step();
    ALUoutput = 16'd12;
    memAddr   = 4'd2;
    readMem   = 1'b1;
    step();
    total++; if (memOut1 !== 16'd12) begin bad++; $display("FAIL iso_wf got=%0d exp=12", memOut1); end
    total++; if (memOut0 !== 16'd0) begin bad++; $display("FAIL iso_rf got=%0d exp=0", memOut0); end
    writeMem = 1'b0;
    memAddr  = 4'd0;
    step();
    total++; if (memOut1 !== 16'd1) begin bad++; $display("FAIL iso_a0 got=%0d exp=1", memOut1); end
    total++; if (memOut0 !== 16'd1) begin bad++; $display("FAIL iso_a0_rf got=%0d exp=1", memOut0); end
  endtask

  task automatic test_mux();
    logic [15:0] exp_v [3];
    exp_v[0] = 16'hA5A5;
    exp_v[1] = 16'h1234;
    exp_v[2] = 16'hFFFF;
    MWD0     = 16'hA5A5;
    MWD2     = 16'h1234;
    MWD3     = 16'hFFFF;
    readMem  = 1'b0;
    writeMem = 1'b1;
    for (int i = 0; i < 3; i++) begin
      memWriteData = (i == 0) ? 2'd0 : 2'(i + 1);
      memAddr      = 4'(3 + i);
      step();
      total++; if (memValid1 !== 1'b0) begin bad++; $display("FAIL mux_wr_valid%0d got=%b exp=0", i, memValid1); end
    end
    writeMem = 1'b0;
    readMem  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      memAddr = 4'(3 + i);
      step();
      total++; if (memOut0 !== exp_v[i]) begin bad++; $display("FAIL mux_rd%0d got=%h exp=%h", i, memOut0, exp_v[i]); end
      total++; if (memValid0 !== 1'b1) begin bad++; $display("FAIL mux_rd_valid%0d got=%b exp=1", i, memValid0); end
    end
    readMem = 1'b0;
  endtask

  task automatic test_read_first();
    writeMem     = 1'b1;
    readMem      = 1'b0;
    memWriteData = 2'd1;
    ALUoutput    = 16'd3;
    memAddr      = 4'd7;
    WEaluOut     = 1'b1;
    step();
    ALUoutput = 16'd9;
    readMem   = 1'b1;
    step();
    total++; if (memOut0 !== 16'd3) begin bad++; $display("FAIL rf_same got=%0d exp=3", memOut0); end
    total++; if (memOut1 !== 16'd9) begin bad++; $display("FAIL wf_same got=%0d exp=9", memOut1); end
    writeMem  = 1'b0;
    WEaluOut  = 1'b0;
    ALUoutput = 16'h5555;
    step();
    total++; if (memOut0 !== 16'd9) begin bad++; $display("FAIL rf_after got=%0d exp=9", memOut0); end
    total++; if (aluOut0 !== 16'd9) begin bad++; $display("FAIL alu_hold got=%h exp=0009", aluOut0); end
    readMem = 1'b0;
  endtask

  task automatic test_mid_sweep();
    int cnt;
    reset = 1'b1;
    step();
    reset        = 1'b0;
    WEaluOut     = 1'b1;
    ALUoutput    = 16'h0077;
    memWriteData = 2'd1;
    writeMem     = 1'b1;
    readMem      = 1'b1;
    memAddr      = 4'd0;
    for (int i = 0; i < 4; i++) step();
    total++; if (aluOut1 !== 16'h0077) begin bad++; $display("FAIL clr_alu got=%h exp=0077", aluOut1); end
    total++; if (memValid1 !== 1'b0) begin bad++; $display("FAIL clr_valid got=%b exp=0", memValid1); end
    total++; if (stall1 !== 1'b1) begin bad++; $display("FAIL mid_stall got=%b exp=1", stall1); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    cnt = 0;
    while (stall1 === 1'b1 && cnt < 40) begin
      step();
      cnt++;
    end
    total++; if (cnt !== 16) begin bad++; $display("FAIL resweep_len got=%0d exp=16", cnt); end
    writeMem = 1'b0;
    step();
    total++; if (memOut1 !== 16'h0) begin bad++; $display("FAIL lost_store got=%h exp=0000", memOut1); end
    total++; if (memOut0 !== 16'h0) begin bad++; $display("FAIL lost_store_rf got=%h exp=0000", memOut0); end
    readMem = 1'b0;
  endtask

  task automatic test_reset_in_run();
    writeMem     = 1'b1;
    readMem      = 1'b0;
    memWriteData = 2'd3;
    MWD3         = 16'h1111;
    memAddr      = 4'd6;
    step();
    reset   = 1'b1;
    MWD3    = 16'h2222;
    readMem = 1'b1;
    step();
    total++; if (memValidN !== 1'b0) begin bad++; $display("FAIL rstrun_valid got=%b exp=0", memValidN); end
    total++; if (stallN !== 1'b0) begin bad++; $display("FAIL rstrun_stall got=%b exp=0", stallN); end
    reset    = 1'b0;
    writeMem = 1'b0;
    step();
    total++; if (memOutN !== 16'h1111) begin bad++; $display("FAIL rstrun_discard got=%h exp=1111", memOutN); end
    total++; if (memValidN !== 1'b1) begin bad++; $display("FAIL rstrun_rd_valid got=%b exp=1", memValidN); end
    readMem = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    writeMem     = 1'b0;
    readMem      = 1'b0;
    WEaluOut     = 1'b0;
    memWriteData = 2'd0;
    ALUoutput    = 16'h0;
    MWD0         = 16'h0;
    MWD2         = 16'h0;
    MWD3         = 16'h0;
    memAddr      = 4'd0;
    test_reset();
    test_write_first();
    test_isolation();
    test_mux();
    test_read_first();
    test_mid_sweep();
    test_reset_in_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
